// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the controller->core instruction interface.
// Holds the bit position of every inst field, the address field ranges
// and the err vector layout. The controller imports the same package,
// so both ends agree on the encoding.
package core_ctrl_pkg;

  localparam int INST_W    = 20;

  // Single-bit command fields of inst
  localparam int SFP_STORE = 19;
  localparam int SFP_ACC   = 18;
  localparam int SFP_DIV   = 17;
  localparam int OFIFO_RD  = 16;
  localparam int EXECUTE   = 7;
  localparam int LOAD      = 6;
  localparam int QMEM_RD   = 5;
  localparam int QMEM_WR   = 4;
  localparam int KMEM_RD   = 3;
  localparam int KMEM_WR   = 2;
  localparam int PMEM_RD   = 1;
  localparam int PMEM_WR   = 0;

  // Address fields of inst
  localparam int QK_ADD_HI = 15;
  localparam int QK_ADD_LO = 12;
  localparam int P_ADD_HI  = 11;
  localparam int P_ADD_LO  = 8;

  // Sticky protocol error bits
  localparam int ERR_W       = 5;
  localparam int ERR_Q_RDWR  = 0;
  localparam int ERR_K_RDWR  = 1;
  localparam int ERR_P_RDWR  = 2;
  localparam int ERR_LD_EXEC = 3;
  localparam int ERR_OVF     = 4;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ERR_W-1:0]  err_t;

endpackage

// File: rtl/core_status_responder_if.sv
// Controller<->core status interface.
//   inst        controller -> core  20-bit instruction word
//   start       controller -> core  begins a new pass
//   ofifo_valid core FIFO  -> core  output FIFO holds a complete row
//   q_full, k_full, ld_done, exec_done, out_wr, p_full
//               core -> controller  sequencing flags
//   err         core -> controller  sticky protocol errors
// master = controller side, slave = core (status responder) side.
interface core_status_responder_if;
  import core_ctrl_pkg::*;

  inst_t inst;
  logic  start;
  logic  ofifo_valid;
  logic  q_full;
  logic  k_full;
  logic  ld_done;
  logic  exec_done;
  logic  out_wr;
  logic  p_full;
  err_t  err;

  modport master (
    output inst, start, ofifo_valid,
    input  q_full, k_full, ld_done, exec_done, out_wr, p_full, err
  );

  modport slave (
    input  inst, start, ofifo_valid,
    output q_full, k_full, ld_done, exec_done, out_wr, p_full, err
  );

endinterface

// File: rtl/sat_event_counter.sv
// Saturating event counter with a registered full flag.
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   clr    in   restart the count (takes priority over plain counting)
//   inc    in   qualifying event this cycle
//   cnt    out  events seen since clr, saturates at DEPTH
//   full   out  registered, 1 once cnt has reached DEPTH
//   ovf    out  combinational, event arriving while already full
module sat_event_counter #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         inc,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         ovf
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          full_q, full_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr) begin
      // An event coincident with clr is the first event of the new pass.
      cnt_d  = inc ? CW'(1) : '0;
      full_d = inc && (DEPTH == 1);
    end else if (inc && !full_q) begin
      cnt_d  = cnt_inc;
      full_d = (cnt_inc == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign cnt  = cnt_q;
  assign full = full_q;
  // Judged against the flag before any clr, so an overflow in a start
  // cycle is still reported.
  assign ovf  = inc & full_q;

endmodule

// File: rtl/core_status_responder.sv
// Core-side status responder for the controller->core instruction bus.
// Counts qmem_wr, kmem_wr, load, execute and pmem_wr-with-ofifo_rd cycles
// since the last start and raises the matching sticky flag once each count
// reaches its depth. Also registers ofifo_valid as out_wr and collects
// sticky protocol errors.
//   clk    in   clock
//   reset  in   asynchronous active-low reset (0 = reset)
//   bus    slave side of core_status_responder_if
//            in : inst, start, ofifo_valid
//            out: q_full, k_full, ld_done, exec_done, out_wr, p_full, err
module core_status_responder
  import core_ctrl_pkg::*;
#(
  parameter int Q_DEPTH  = 8,
  parameter int K_DEPTH  = 8,
  parameter int LOAD_CYC = 8,
  parameter int EXEC_CYC = 8,
  parameter int P_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  core_status_responder_if.slave bus
);

  inst_t inst;
  logic  start;

  assign inst  = bus.inst;
  assign start = bus.start;

  logic q_inc, k_inc, l_inc, e_inc, p_inc;

  assign q_inc = inst[QMEM_WR];
  assign k_inc = inst[KMEM_WR];
  assign l_inc = inst[LOAD];
  assign e_inc = inst[EXECUTE];
  // SFP write-back (pmem_wr without ofifo_rd) does not fill PMEM.
  assign p_inc = inst[PMEM_WR] & inst[OFIFO_RD];

  logic [$clog2(Q_DEPTH+1)-1:0]  q_cnt;
  logic [$clog2(K_DEPTH+1)-1:0]  k_cnt;
  logic [$clog2(LOAD_CYC+1)-1:0] l_cnt;
  logic [$clog2(EXEC_CYC+1)-1:0] e_cnt;
  logic [$clog2(P_DEPTH+1)-1:0]  p_cnt;

  logic q_full, k_full, ld_done, exec_done, p_full;
  logic q_ovf, k_ovf, l_ovf, e_ovf, p_ovf;

  sat_event_counter #(.DEPTH(Q_DEPTH)) u_q_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(q_inc),
    .cnt(q_cnt), .full(q_full), .ovf(q_ovf)
  );

  sat_event_counter #(.DEPTH(K_DEPTH)) u_k_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(k_inc),
    .cnt(k_cnt), .full(k_full), .ovf(k_ovf)
  );

  sat_event_counter #(.DEPTH(LOAD_CYC)) u_l_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(l_inc),
    .cnt(l_cnt), .full(ld_done), .ovf(l_ovf)
  );

  sat_event_counter #(.DEPTH(EXEC_CYC)) u_e_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(e_inc),
    .cnt(e_cnt), .full(exec_done), .ovf(e_ovf)
  );

  sat_event_counter #(.DEPTH(P_DEPTH)) u_p_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(p_inc),
    .cnt(p_cnt), .full(p_full), .ovf(p_ovf)
  );

  err_t err_q, err_d, err_new;
  logic out_wr_q, out_wr_d;

  always_comb begin
    err_new              = '0;
    err_new[ERR_Q_RDWR]  = inst[QMEM_RD] & inst[QMEM_WR];
    err_new[ERR_K_RDWR]  = inst[KMEM_RD] & inst[KMEM_WR];
    err_new[ERR_P_RDWR]  = inst[PMEM_RD] & inst[PMEM_WR];
    err_new[ERR_LD_EXEC] = inst[LOAD] & inst[EXECUTE];
    // Only the memory writes can run past a full SRAM.
    err_new[ERR_OVF]     = q_ovf | k_ovf | p_ovf;
    // start wipes history but the current cycle's errors still land.
    err_d    = (start ? '0 : err_q) | err_new;
    out_wr_d = bus.ofifo_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q    <= '0;
      out_wr_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      out_wr_q <= out_wr_d;
    end
  end

  assign bus.q_full    = q_full;
  assign bus.k_full    = k_full;
  assign bus.ld_done   = ld_done;
  assign bus.exec_done = exec_done;
  assign bus.p_full    = p_full;
  assign bus.out_wr    = out_wr_q;
  assign bus.err       = err_q;

  // SFP controls, address fields, load/execute overruns and raw counts are
  // not used by this block.
  logic unused_ok;
  assign unused_ok = ^{inst[SFP_STORE], inst[SFP_ACC], inst[SFP_DIV],
                       inst[QK_ADD_HI:QK_ADD_LO], inst[P_ADD_HI:P_ADD_LO],
                       l_ovf, e_ovf, q_cnt, k_cnt, l_cnt, e_cnt, p_cnt};

endmodule
